// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    localparam int unsigned BIN_W       = 14;
    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned SHIFT_COUNT = 14;
    localparam int unsigned SCRATCH_W   = 4 * (NUM_DIGITS + 1);
    localparam int unsigned CNT_W       = 4;

    localparam logic [4*NUM_DIGITS-1:0] BCD_SAT = 16'h9999;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFinish
    } state_e;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the converter and its producer/display side.
interface bin2bcd_seq_if;
    import bin2bcd_seq_pkg::*;

    logic                      start;
    logic [BIN_W-1:0]          bin;
    logic                      busy;
    logic                      done;
    logic [4*NUM_DIGITS-1:0]   bcd;
    logic                      ovf;

    modport master (output start, output bin, input busy, input done, input bcd, input ovf);
    modport slave  (input start, input bin, output busy, output done, output bcd, output ovf);

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative 14-bit binary to 4-digit BCD converter (shift-and-add-3).
// Define BIN2BCD_SAT_EN to clamp bcd to 9999 when the input exceeds 9999.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
(
    input  logic               clk_1MHz,
    input  logic               rst_n,
    bin2bcd_seq_if.slave       bus
);

    state_e                    r_state, w_state_nxt;
    logic [BIN_W-1:0]          r_shreg, w_shreg_nxt;
    logic [SCRATCH_W-1:0]      r_scratch, w_scratch_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic [4*NUM_DIGITS-1:0]   r_bcd, w_bcd_nxt;
    logic                      r_ovf, w_ovf_nxt;
    logic                      r_done, w_done_nxt;
    logic [SCRATCH_W-1:0]      w_adj;
    logic                      w_ovf_raw;

    for (genvar g = 0; g < NUM_DIGITS + 1; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    assign w_ovf_raw = |r_scratch[SCRATCH_W-1 -: 4];

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_scratch_nxt = r_scratch;
        w_cnt_nxt     = r_cnt;
        w_bcd_nxt     = r_bcd;
        w_ovf_nxt     = r_ovf;
        w_done_nxt    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_shreg_nxt   = bus.bin;
                    w_scratch_nxt = '0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = StShift;
                end
            end
            StShift: begin
                // Rotate rather than shift: the top scratch bit is always 0 and the
                // bit fed back into shreg never reaches scratch within 14 steps.
                w_scratch_nxt = {w_adj[SCRATCH_W-2:0], r_shreg[BIN_W-1]};
                w_shreg_nxt   = {r_shreg[BIN_W-2:0], w_adj[SCRATCH_W-1]};
                w_cnt_nxt     = r_cnt + 1'b1;
                if (r_cnt == CNT_W'(SHIFT_COUNT - 1)) begin
                    w_state_nxt = StFinish;
                end
            end
            StFinish: begin
                w_ovf_nxt   = w_ovf_raw;
`ifdef BIN2BCD_SAT_EN
                w_bcd_nxt   = w_ovf_raw ? BCD_SAT : r_scratch[4*NUM_DIGITS-1:0];
`else
                w_bcd_nxt   = r_scratch[4*NUM_DIGITS-1:0];
`endif
                w_done_nxt  = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_scratch <= w_scratch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bcd     <= w_bcd_nxt;
            r_ovf     <= w_ovf_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.busy = (r_state != StIdle);
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq; honours BIN2BCD_SAT_EN.
`timescale 1ns / 1ps
module tb_bin2bcd_seq;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bin2bcd_seq_if bus ();

    bin2bcd_seq u_dut (
        .clk_1MHz (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

`ifdef BIN2BCD_SAT_EN
    localparam logic [15:0] EXP_10000 = 16'h9999;
    localparam logic [15:0] EXP_16383 = 16'h9999;
`else
    localparam logic [15:0] EXP_10000 = 16'h0000;
    localparam logic [15:0] EXP_16383 = 16'h6383;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_bcd"},  32'(bus.bcd),  32'h0000);
        check_eq({tag, "_ovf"},  32'(bus.ovf),  32'd0);
    endtask

    // Sample index i is the negedge after edge E(i); busy expected for i=0..14, done at i=15.
    task automatic run_conv(input string tag, input logic [13:0] v, input logic [15:0] exp_bcd,
                            input logic exp_ovf, input logic [15:0] prev_bcd, input int inj_at);
        int n_busy;
        int n_done;
        int done_idx;
        n_busy   = 0;
        n_done   = 0;
        done_idx = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = v;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy) n_busy++;
            if (bus.done) begin
                n_done++;
                done_idx = i;
            end
            if (i == 7) check_eq({tag, "_hold_mid"}, 32'(bus.bcd), 32'(prev_bcd));
            if (i == 0) begin
                bus.start = 1'b0;
                bus.bin   = 14'h3fff;
            end
            if (i == inj_at) begin
                bus.start = 1'b1;
                bus.bin   = 14'd777;
            end
            if (i == inj_at + 1) bus.start = 1'b0;
        end
        check_eq({tag, "_busy_cycles"}, 32'(n_busy),   32'd15);
        check_eq({tag, "_done_pulses"}, 32'(n_done),   32'd1);
        check_eq({tag, "_done_edge"},   32'(done_idx), 32'd15);
        check_eq({tag, "_bcd"},         32'(bus.bcd),  32'(exp_bcd));
        check_eq({tag, "_ovf"},         32'(bus.ovf),  32'(exp_ovf));
    endtask

    initial begin
        int n_done;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;

        run_conv("c1234", 14'd1234, 16'h1234, 1'b0, 16'h0000, -10);

        // Reset while idle clears the held result.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("idle_rst");
        @(negedge clk);
        rst_n = 1'b1;

        run_conv("c0",     14'd0,     16'h0000,  1'b0, 16'h0000, -10);
        run_conv("c9999",  14'd9999,  16'h9999,  1'b0, 16'h0000, -10);
        run_conv("c10000", 14'd10000, EXP_10000, 1'b1, 16'h9999, -10);
        run_conv("c16383", 14'd16383, EXP_16383, 1'b1, EXP_10000, -10);

        // Start at E5 during the conversion of 42 must be dropped.
        run_conv("c42", 14'd42, 16'h0042, 1'b0, EXP_16383, 4);
        run_conv("c777", 14'd777, 16'h0777, 1'b0, 16'h0042, -10);
        run_conv("c42b", 14'd42, 16'h0042, 1'b0, 16'h0777, -10);

        // Abort the conversion of 5678 just after E7.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 14'd5678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        n_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check_eq("abort_no_done", 32'(n_done), 32'd0);
        check_eq("abort_bcd_after", 32'(bus.bcd), 32'h0000);

        run_conv("c5678", 14'd5678, 16'h5678, 1'b0, 16'h0000, -10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
